wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage of the ARM pipeline; drives the register file write port (Dest_wb, Result_WB, writeBackEn).
//  Accepts one retiring instruction per cycle from MEM and selects ALU result or load data.
//  Waits on late load data with a small FSM, stalls MEM meanwhile, and reports the pending destination to the hazard unit.
//  Outputs are registered; the register file samples them on the following negedge clk.
// PARAMETERS
//  DATA_W      32   data/result width
//  REG_AW      4    register index width (16 architectural regs)
//  LD_TIMEOUT  255  max cycles in WAIT_LD before abort; counter width = $clog2(LD_TIMEOUT+1)
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-low reset
//  mem_valid      in   1       MEM presents a retiring instruction this cycle
//  mem_ready      out  1       wb_stage accepts it (transfer = mem_valid & mem_ready)
//  mem_wb_en      in   1       instruction writes a register
//  mem_r_en       in   1       instruction is a load (result comes from ld_data)
//  mem_dest       in   REG_AW  destination register index
//  mem_alu_res    in   DATA_W  ALU result
//  ld_data_valid  in   1       load data present (one-cycle qualifier)
//  ld_data        in   DATA_W  load data
//  Dest_wb        out  REG_AW  register file write index
//  Result_WB      out  DATA_W  register file write data
//  writeBackEn    out  1       register file write strobe, one cycle per write
//  pc_wr          out  1       pulses with writeBackEn when Dest_wb == 15
//  pend_valid     out  1       a load write is pending (state WAIT_LD)
//  pend_dest      out  REG_AW  destination of pending load (valid when pend_valid)
//  ld_err         out  1       one-cycle pulse on load timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; Dest_wb=0, Result_WB=0, writeBackEn=0, pc_wr=0, pend_valid=0, pend_dest=0,
//   ld_err=0, timeout counter=0. mem_ready=1 after reset. Reset mid-WAIT_LD drops the pending load; no write issued.
//  mem_ready = (state==IDLE), combinational from state only.
//  IDLE, transfer accepted:
//   - mem_wb_en=0: no write; stay IDLE (stores/compares).
//   - mem_wb_en=1, mem_r_en=0: next posedge Dest_wb<=mem_dest, Result_WB<=mem_alu_res, writeBackEn<=1. Latency 1.
//   - mem_wb_en=1, mem_r_en=1, ld_data_valid=1 same cycle: as above with Result_WB<=ld_data; stay IDLE.
//   - mem_wb_en=1, mem_r_en=1, ld_data_valid=0: capture mem_dest into pend_dest, pend_valid<=1, cnt<=0, go WAIT_LD.
//  IDLE, ld_data_valid with no load transfer: ignored.
//  WAIT_LD (mem_ready=0, MEM holds its inputs):
//   - ld_data_valid=1: Dest_wb<=pend_dest, Result_WB<=ld_data, writeBackEn<=1, pend_valid<=0, go IDLE.
//   - else cnt==LD_TIMEOUT-1: ld_err<=1 one cycle, pend_valid<=0, no write, go IDLE.
//   - else cnt<=cnt+1. ld_data_valid on the timeout cycle wins (write, no ld_err).
//  writeBackEn, pc_wr, ld_err are single-cycle pulses; cleared the cycle after unless a new write/error occurs.
//   Back-to-back ALU writes hold writeBackEn=1 continuously with new Dest_wb/Result_WB each cycle.
//  Dest_wb/Result_WB hold last written value when writeBackEn=0.
//  pc_wr = writeBackEn & (Dest_wb == 4'hF), registered alongside.
//  No arithmetic on data; widths pass through unchanged. Throughput 1/cycle except loads with late data.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0 immediately, mem_ready=1 after release.
//  2 ALU write: mem_valid=1, wb_en=1, r_en=0, dest=3, alu=0x1234 -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0x1234; regfile R3=0x1234.
//  3 Late load: load dest=5, data valid 4 cycles later with 0xDEADBEEF -> pend_valid=1/pend_dest=5 and mem_ready=0 for 4 cycles, then write R5=0xDEADBEEF, mem_ready=1.
//  4 Timeout: load dest=7, no ld_data_valid -> after LD_TIMEOUT cycles ld_err pulses once, no writeBackEn, back to IDLE.
//  5 PC write + streaming: dests 14,15,0 on consecutive cycles -> writeBackEn high 3 cycles, pc_wr only on dest 15.
//  6 Store: wb_en=0 -> no writeBackEn; ld_data_valid spurious in IDLE -> ignored.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-writeback handshake plus register-file write port and hazard-unit view.
// slave = wb_stage side, master = the MEM stage / register file / hazard unit side.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wb_en;
  logic              mem_r_en;
  logic [REG_AW-1:0] mem_dest;
  logic [DATA_W-1:0] mem_alu_res;
  logic              ld_data_valid;
  logic [DATA_W-1:0] ld_data;
  logic [REG_AW-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic              writeBackEn;
  logic              pc_wr;
  logic              pend_valid;
  logic [REG_AW-1:0] pend_dest;
  logic              ld_err;

  modport slave (
    input  mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res, ld_data_valid, ld_data,
    output mem_ready, Dest_wb, Result_WB, writeBackEn, pc_wr, pend_valid, pend_dest, ld_err
  );

  modport master (
    output mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res, ld_data_valid, ld_data,
    input  mem_ready, Dest_wb, Result_WB, writeBackEn, pc_wr, pend_valid, pend_dest, ld_err
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU result or load data, waits on late loads with a
// two-state FSM and bounded timeout, and drives a registered register-file write port.
module wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 4,
  parameter int LD_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(LD_TIMEOUT + 1);
  localparam logic [REG_AW-1:0] PC_IDX   = {REG_AW{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] result_q;
  logic              wb_en_q;
  logic              pc_wr_q;
  logic              pend_valid_q;
  logic [REG_AW-1:0] pend_dest_q;
  logic              ld_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dest_q       <= '0;
      result_q     <= '0;
      wb_en_q      <= 1'b0;
      pc_wr_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dest_q  <= '0;
      ld_err_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      wb_en_q  <= 1'b0;
      pc_wr_q  <= 1'b0;
      ld_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mem_valid && bus.mem_wb_en) begin
            if (!bus.mem_r_en || bus.ld_data_valid) begin
              dest_q   <= bus.mem_dest;
              result_q <= bus.mem_r_en ? bus.ld_data : bus.mem_alu_res;
              wb_en_q  <= 1'b1;
              pc_wr_q  <= (bus.mem_dest == PC_IDX);
            end else begin
              pend_dest_q  <= bus.mem_dest;
              pend_valid_q <= 1'b1;
              cnt_q        <= '0;
              state_q      <= WAIT_LD;
            end
          end
        end
        WAIT_LD: begin
          // Data arriving on the last allowed cycle still beats the timeout.
          if (bus.ld_data_valid) begin
            dest_q       <= pend_dest_q;
            result_q     <= bus.ld_data;
            wb_en_q      <= 1'b1;
            pc_wr_q      <= (pend_dest_q == PC_IDX);
            pend_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ld_err_q     <= 1'b1;
            pend_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_ready   = (state_q == IDLE);
  assign bus.Dest_wb     = dest_q;
  assign bus.Result_WB   = result_q;
  assign bus.writeBackEn = wb_en_q;
  assign bus.pc_wr       = pc_wr_q;
  assign bus.pend_valid  = pend_valid_q;
  assign bus.pend_dest   = pend_dest_q;
  assign bus.ld_err      = ld_err_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes expected write/error events,
// a negedge monitor pops and compares them against the register-file port.
module tb_wb_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int LD_TO  = 16;

  typedef struct {
    bit          err;
    logic [3:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  logic [3:0]  last_dest = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LD_TIMEOUT(LD_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    else n_pass++;
  endfunction

  function automatic void push_wr(logic [3:0] d, logic [31:0] v);
    exp_t e;
    e.err = 1'b0; e.dest = d; e.data = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_err();
    exp_t e;
    e.err = 1'b1; e.dest = '0; e.data = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: every write strobe or error pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_dest = '0;
        last_data = '0;
        continue;
      end
      if (bus.writeBackEn || bus.ld_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got wb=%0b err=%0b dest=%0d, required none",
                   bus.writeBackEn, bus.ld_err, bus.Dest_wb);
        end else begin
          e = exp_q.pop_front();
          if (e.err) begin
            chk("ld_err", 32'(bus.ld_err), 32'd1);
            chk("err_no_write", 32'(bus.writeBackEn), 32'd0);
          end else begin
            chk("wb_en", 32'(bus.writeBackEn), 32'd1);
            chk("dest_wb", 32'(bus.Dest_wb), 32'(e.dest));
            chk("result_wb", bus.Result_WB, e.data);
            chk("pc_wr", 32'(bus.pc_wr), 32'(e.dest == 4'hF));
            last_dest = e.dest;
            last_data = e.data;
          end
        end
      end else begin
        chk("pc_wr_quiet", 32'(bus.pc_wr), 32'd0);
        chk("dest_hold", 32'(bus.Dest_wb), 32'(last_dest));
        chk("result_hold", bus.Result_WB, last_data);
      end
    end
  end

  task automatic clear_inputs();
    bus.mem_valid     = 1'b0;
    bus.mem_wb_en     = 1'b0;
    bus.mem_r_en      = 1'b0;
    bus.mem_dest      = '0;
    bus.mem_alu_res   = '0;
    bus.ld_data_valid = 1'b0;
    bus.ld_data       = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One retiring instruction. delay = cycles after the transfer until load data
  // appears (0 = same cycle); anything beyond LD_TO never arrives.
  task automatic issue(input bit wb, input bit r, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] ldv,
                       input int delay, input bit spur);
    $display("txn wb=%0b r=%0b dest=%0d alu=0x%08h ld=0x%08h delay=%0d spur=%0b",
             wb, r, dest, alu, ldv, delay, spur);
    chk("mem_ready_idle", 32'(bus.mem_ready), 32'd1);
    chk("pend_valid_idle", 32'(bus.pend_valid), 32'd0);
    bus.mem_valid   = 1'b1;
    bus.mem_wb_en   = wb;
    bus.mem_r_en    = r;
    bus.mem_dest    = dest;
    bus.mem_alu_res = alu;
    bus.ld_data     = (wb && r) ? ldv : $urandom;
    bus.ld_data_valid = (wb && r) ? (delay == 0) : spur;
    if (wb && !r) push_wr(dest, alu);
    else if (wb && r && delay == 0) push_wr(dest, ldv);
    step();
    if (wb && r && delay > 0) begin
      for (int k = 1; k <= LD_TO; k++) begin
        chk("mem_ready_wait", 32'(bus.mem_ready), 32'd0);
        chk("pend_valid_wait", 32'(bus.pend_valid), 32'd1);
        chk("pend_dest", 32'(bus.pend_dest), 32'(dest));
        bus.ld_data_valid = (k == delay);
        bus.ld_data       = (k == delay) ? ldv : $urandom;
        if (k == delay) push_wr(dest, ldv);
        else if (k == LD_TO) push_err();
        step();
        if (k == delay) break;
      end
    end
    bus.mem_valid     = 1'b0;
    bus.ld_data_valid = 1'b0;
  endtask

  task automatic idle_cycle(input bit spur);
    $display("txn idle spur=%0b", spur);
    bus.mem_valid     = 1'b0;
    bus.ld_data_valid = spur;
    bus.ld_data       = $urandom;
    step();
    bus.ld_data_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_dest", 32'(bus.Dest_wb), 32'd0);
    chk("rst_result", bus.Result_WB, 32'd0);
    chk("rst_wb_en", 32'(bus.writeBackEn), 32'd0);
    chk("rst_pc_wr", 32'(bus.pc_wr), 32'd0);
    chk("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
    chk("rst_pend_dest", 32'(bus.pend_dest), 32'd0);
    chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
  endtask

  initial begin
    int kind;
    int dly;
    clear_inputs();
    #1;
    check_reset_state();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed: ALU write, late load, timeout, PC streaming, store and spurious data.
    issue(1, 0, 4'd3, 32'h0000_1234, 32'h0, 0, 0);
    issue(1, 1, 4'd5, 32'h0, 32'hDEAD_BEEF, 4, 0);
    issue(1, 1, 4'd7, 32'h0, 32'h0, LD_TO + 5, 0);
    idle_cycle(0);
    issue(1, 0, 4'd14, 32'hAAAA_0014, 32'h0, 0, 0);
    issue(1, 0, 4'd15, 32'hAAAA_0015, 32'h0, 0, 0);
    issue(1, 0, 4'd0, 32'hAAAA_0000, 32'h0, 0, 0);
    issue(0, 0, 4'd9, 32'h5555_5555, 32'h0, 0, 1);
    idle_cycle(1);
    issue(1, 1, 4'd15, 32'h0, 32'hC0DE_0015, 0, 0);
    issue(1, 1, 4'd2, 32'h0, 32'h1111_2222, LD_TO, 0);
    issue(1, 1, 4'd4, 32'h0, 32'h3333_4444, LD_TO - 1, 0);
    issue(1, 1, 4'd15, 32'h0, 32'h7777_0015, 1, 0);

    // Reset in the middle of a pending load drops it without a write.
    $display("txn reset during WAIT_LD");
    bus.mem_valid = 1'b1; bus.mem_wb_en = 1'b1; bus.mem_r_en = 1'b1;
    bus.mem_dest = 4'd9; bus.ld_data_valid = 1'b0;
    step();
    step();
    chk("pend_before_rst", 32'(bus.pend_valid), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_state();
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.mem_ready), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) dly = $urandom_range(0, LD_TO + 3);
      else dly = $urandom_range(0, 3);
      case (kind)
        0:       idle_cycle(1'($urandom_range(0, 1)));
        1:       issue(0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 0,
                       1'($urandom_range(0, 1)));
        2, 3, 4: issue(1, 1, 4'($urandom), $urandom, $urandom, dly, 0);
        default: issue(1, 0, 4'($urandom), $urandom, $urandom, 0, 1'($urandom_range(0, 1)));
      endcase
    end

    idle_cycle(0);
    idle_cycle(0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
